serial_frame_rx: RTL

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

---
 rtl/serial_pkg.sv | 13 +
 rtl/shift_reg_ar.sv | 22 ++
 rtl/serial_frame_rx.sv | 112 +++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial frame receiver.
package serial_pkg;

  localparam int unsigned WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    STOP  = 2'd2,
    BREAK = 2'd3
  } rx_state_t;

endpackage

// File: rtl/shift_reg_ar.sv
// Right-shifting register with asynchronous clear; new bits enter at the MSB.
module shift_reg_ar
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= {din, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits LSB first, stop bit,
// with overrun and framing-error reporting and a break state for held-low lines.
module serial_frame_rx
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             R,
  input  logic             Din,
  input  logic             ack,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             ferr,
  output logic             ovr,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  rx_state_t        state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic             sh_en;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] data_next;
  logic             valid_next;
  logic             ferr_next;
  logic             ovr_next;
  logic             busy_next;

  shift_reg_ar #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk (clk),
    .rst (R),
    .en  (sh_en),
    .din (Din),
    .q   (sh_q)
  );

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state <= IDLE;
      cnt   <= '0;
      data  <= '0;
      valid <= 1'b0;
      ferr  <= 1'b0;
      ovr   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      data  <= data_next;
      valid <= valid_next;
      ferr  <= ferr_next;
      ovr   <= ovr_next;
      busy  <= busy_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    sh_en      = 1'b0;
    data_next  = data;
    valid_next = valid;
    ferr_next  = 1'b0;
    ovr_next   = 1'b0;

    if (valid && ack) begin
      valid_next = 1'b0;
    end

    unique case (state)
      IDLE: begin
        if (!Din) begin
          state_next = DATA;
          cnt_next   = '0;
        end
      end
      DATA: begin
        sh_en    = 1'b1;
        cnt_next = cnt + CW'(1);
        if (cnt == LAST_BIT) begin
          state_next = STOP;
        end
      end
      STOP: begin
        if (Din) begin
          // A completing frame wins over a same-edge ack; overrun only if unacked.
          data_next  = sh_q;
          valid_next = 1'b1;
          ovr_next   = valid && !ack;
          state_next = IDLE;
        end else begin
          ferr_next  = 1'b1;
          state_next = BREAK;
        end
      end
      BREAK: begin
        if (Din) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

endmodule
